// File: rtl/riscv_ctrl_pkg.sv
// Shared types and constants for the RV32I multi-cycle control unit.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_RF  = 2'b10;
  localparam logic [1:0] ALUOP_IF  = 2'b11;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_MEMTMO  = 2'b10;

  // Bit positions of the one-hot instruction class vector.
  localparam int CLS_R      = 0;
  localparam int CLS_I      = 1;
  localparam int CLS_LOAD   = 2;
  localparam int CLS_STORE  = 3;
  localparam int CLS_BRANCH = 4;
  localparam int CLS_JAL    = 5;
  localparam int CLS_JALR   = 6;
  localparam int CLS_LUI    = 7;
  localparam int CLS_AUIPC  = 8;
  localparam int CLS_N      = 9;

endpackage

// File: rtl/mc_opdecode.sv
// Maps a 7-bit RV32I opcode to a one-hot instruction class and a legal flag.
module mc_opdecode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0]       opcode_i,
  output logic [CLS_N-1:0] cls_o,
  output logic             legal_o
);

  always_comb begin
    cls_o = '0;
    case (opcode_i)
      OP_R:      cls_o[CLS_R]      = 1'b1;
      OP_I:      cls_o[CLS_I]      = 1'b1;
      OP_LOAD:   cls_o[CLS_LOAD]   = 1'b1;
      OP_STORE:  cls_o[CLS_STORE]  = 1'b1;
      OP_BRANCH: cls_o[CLS_BRANCH] = 1'b1;
      OP_JAL:    cls_o[CLS_JAL]    = 1'b1;
      OP_JALR:   cls_o[CLS_JALR]   = 1'b1;
      OP_LUI:    cls_o[CLS_LUI]    = 1'b1;
      OP_AUIPC:  cls_o[CLS_AUIPC]  = 1'b1;
      default:   cls_o             = '0;
    endcase
  end

  assign legal_o = |cls_o;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving the RV32I datapath controls.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int TMO_W       = 4,
  parameter int MEM_TIMEOUT = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             ALUsrc,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Branch,
  output logic             Jump,
  output logic             Jalr,
  output logic             AUI,
  output logic             Lui,
  output logic [1:0]       ALUOp,
  output logic             halt,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state_o
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [6:0]       op_q, op_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;

  logic [CLS_N-1:0] dec_cls, op_cls;
  logic             dec_legal, op_legal;
  logic             op_mem;

  mc_opdecode u_dec_in (
    .opcode_i (opcode),
    .cls_o    (dec_cls),
    .legal_o  (dec_legal)
  );

  mc_opdecode u_dec_op (
    .opcode_i (op_q),
    .cls_o    (op_cls),
    .legal_o  (op_legal)
  );

  assign op_mem = op_cls[CLS_LOAD] | op_cls[CLS_STORE];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      tmo_q   <= '0;
      cause_q <= CAUSE_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tmo_q   <= tmo_d;
      cause_q <= cause_d;
      if (PCWrite) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // run is registered so FETCH outputs never follow the pin combinationally;
  // it keeps sampling during reset so a fetch can start on the first clock after release.
  always_ff @(posedge clk) begin
    run_q <= run;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    tmo_d   = tmo_q;
    cause_d = cause_q;
    case (state_q)
      S_FETCH: if (run_q) state_d = S_DECODE;
      S_DECODE: begin
        op_d = opcode;
        if (dec_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        if (op_mem) begin
          state_d = S_MEM;
          tmo_d   = '0;
        end else if (op_cls[CLS_BRANCH]) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          state_d = S_WB;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_TRAP;
          cause_d = CAUSE_MEMTMO;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    MemtoReg = 1'b0;
    ALUsrc   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Branch   = 1'b0;
    Jump     = 1'b0;
    Jalr     = 1'b0;
    AUI      = 1'b0;
    Lui      = 1'b0;
    ALUOp    = ALUOP_ADD;

    if (state_q == S_FETCH && run_q && reset) IRWrite = 1'b1;

    // ALU and PC-source selects set in EXEC are held through MEM and WB.
    if ((state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) && op_legal) begin
      if (op_cls[CLS_R]) ALUOp = ALUOP_RF;
      if (op_cls[CLS_I]) begin
        ALUOp  = ALUOP_IF;
        ALUsrc = 1'b1;
      end
      if (op_mem) ALUsrc = 1'b1;
      if (op_cls[CLS_BRANCH]) ALUOp = ALUOP_BR;
      if (op_cls[CLS_JAL] || op_cls[CLS_JALR] || op_cls[CLS_AUIPC]) begin
        ALUsrc = 1'b1;
        AUI    = 1'b1;
      end
      if (op_cls[CLS_JAL])  Jump = 1'b1;
      if (op_cls[CLS_JALR]) Jalr = 1'b1;
      if (op_cls[CLS_LUI]) begin
        ALUsrc = 1'b1;
        Lui    = 1'b1;
      end
    end

    case (state_q)
      S_EXEC: begin
        if (op_cls[CLS_BRANCH]) begin
          Branch  = 1'b1;
          PCWrite = 1'b1;
        end
      end
      S_MEM: begin
        MemRead  = op_cls[CLS_LOAD];
        MemWrite = op_cls[CLS_STORE];
      end
      S_WB: begin
        PCWrite  = 1'b1;
        RegWrite = ~op_cls[CLS_STORE];
        MemtoReg = op_cls[CLS_LOAD];
      end
      default: ;
    endcase
  end

  assign halt       = (state_q == S_TRAP);
  assign trap_cause = cause_q;
  assign instret    = cnt_q;
  assign state_o    = state_q;

endmodule
